// File: rtl/tetris_piece_ctrl.sv
// Piece sequencer for the 10x21 playfield memory: spawn, gravity, lateral moves, lock and clear restart.
// Optional macro ROTATE_EN enables in-place rotation of I and L1 pieces.
module tetris_piece_ctrl #(
    parameter int unsigned SPAWN_ADDR = 14,
    parameter int unsigned DROP_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tick,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    input  logic        i_btn_drop,
    input  logic        i_btn_rot,
    input  logic [2:0]  i_piece_sel,
    input  logic        i_is_reach,
    input  logic        i_clear,
    output logic        o_we,
    output logic [8:0]  o_addr_w,
    output logic [8:0]  o_addr_e,
    output logic [11:0] o_din,
    output logic [11:0] o_din_e,
    output logic [1:0]  o_left_rotate,
    output logic [15:0] o_piece_cnt,
    output logic        o_game_over,
    output logic [2:0]  o_state
);

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned CLR_W    = 12;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DCNT_W   = 8;
    localparam int unsigned ROW_STEP = 10;

    localparam logic [ADDR_W-1:0] SPAWN_A   = ADDR_W'(SPAWN_ADDR);
    localparam logic [COL_W-1:0]  SPAWN_COL = COL_W'(SPAWN_ADDR % ROW_STEP);
    localparam logic [DCNT_W-1:0] DROP_LAST = DCNT_W'(DROP_DIV - 1);
    localparam logic [ADDR_W-1:0] ROW_INC   = ADDR_W'(ROW_STEP);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_FALL  = 3'd2,
        ST_MOVE  = 3'd3,
        ST_LOCK  = 3'd4,
        ST_CLR   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        PC_I  = 3'd0,
        PC_L1 = 3'd1,
        PC_L2 = 3'd2,
        PC_O  = 3'd3,
        PC_Z1 = 3'd4,
        PC_Z2 = 3'd5,
        PC_T  = 3'd6
    } piece_t;

    function automatic logic [CLR_W-1:0] f_colour(input piece_t pc);
        logic [CLR_W-1:0] v;
        case (pc)
            PC_L1:   v = 12'h00f;
            PC_L2:   v = 12'hf80;
            PC_O:    v = 12'hff0;
            PC_Z1:   v = 12'h8f8;
            PC_Z2:   v = 12'hf00;
            PC_T:    v = 12'hf0f;
            default: v = 12'h88f;
        endcase
        return v;
    endfunction

    // Leftmost legal anchor column for a piece/orientation
    function automatic logic [COL_W-1:0] f_lmin(input piece_t pc, input logic [1:0] rot);
        logic [COL_W-1:0] v;
        if (pc == PC_Z2 || (pc == PC_L1 && rot == 2'd3)) begin
            v = 4'd1;
        end else begin
            v = 4'd0;
        end
        return v;
    endfunction

    // Rightmost legal anchor column for a piece/orientation
    function automatic logic [COL_W-1:0] f_rmax(input piece_t pc, input logic [1:0] rot);
        logic [COL_W-1:0] v;
        case (pc)
            PC_I:    v = rot[0] ? 4'd9 : 4'd6;
            PC_L1: begin
                case (rot)
                    2'd1:    v = 4'd8;
                    2'd3:    v = 4'd9;
                    default: v = 4'd7;
                endcase
            end
            PC_O,
            PC_Z2:   v = 4'd8;
            default: v = 4'd7;
        endcase
        return v;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   r_addr_w;
    logic [ADDR_W-1:0]   w_addr_w_nxt;
    logic [ADDR_W-1:0]   r_addr_e;
    logic [ADDR_W-1:0]   w_addr_e_nxt;
    logic [CLR_W-1:0]    r_din;
    logic [CLR_W-1:0]    w_din_nxt;
    logic [1:0]          r_rot;
    logic [1:0]          w_rot_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_game_over;
    logic                w_game_over_nxt;
    piece_t              r_piece;
    piece_t              w_piece_nxt;
    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    w_col_nxt;
    logic                r_drop;
    logic                w_drop_nxt;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [DCNT_W-1:0]   w_dcnt_nxt;
    logic                w_timer;
    logic                w_down;
    piece_t              w_sel_piece;

    assign w_timer     = r_drop && (r_dcnt == DROP_LAST);
    assign w_down      = i_tick || w_timer;
    assign w_sel_piece = (i_piece_sel == 3'd7) ? PC_I : piece_t'(i_piece_sel);

`ifdef ROTATE_EN
    logic [1:0] w_rot_inc;
    assign w_rot_inc = r_rot + 2'd1;
`else
    logic w_unused_rot;
    assign w_unused_rot = i_btn_rot;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = 1'b0;
        w_addr_w_nxt    = r_addr_w;
        w_addr_e_nxt    = r_addr_e;
        w_din_nxt       = r_din;
        w_rot_nxt       = r_rot;
        w_cnt_nxt       = r_cnt;
        w_game_over_nxt = 1'b0;
        w_piece_nxt     = r_piece;
        w_col_nxt       = r_col;
        w_drop_nxt      = r_drop;
        w_dcnt_nxt      = r_dcnt;

        // Drop timer saturates until FALL consumes it
        if (r_drop && (r_dcnt != DROP_LAST)) begin
            w_dcnt_nxt = r_dcnt + 8'd1;
        end

        if (i_clear && (r_state != ST_IDLE)) begin
            w_game_over_nxt = (r_state != ST_CLR);
            w_state_nxt     = ST_CLR;
            w_cnt_nxt       = '0;
            w_drop_nxt      = 1'b0;
            w_dcnt_nxt      = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SPAWN;
                end
                ST_SPAWN: begin
                    w_piece_nxt  = w_sel_piece;
                    w_din_nxt    = f_colour(w_sel_piece);
                    w_rot_nxt    = 2'd0;
                    w_addr_w_nxt = SPAWN_A;
                    w_addr_e_nxt = SPAWN_A;
                    w_col_nxt    = SPAWN_COL;
                    w_we_nxt     = 1'b1;
                    w_cnt_nxt    = r_cnt + 16'd1;
                    w_state_nxt  = ST_FALL;
                end
                ST_FALL: begin
                    if (i_btn_drop) begin
                        w_drop_nxt = 1'b1;
                        w_dcnt_nxt = '0;
                    end
                    if (w_down) begin
                        if (w_timer) begin
                            w_dcnt_nxt = '0;
                        end
                        if (i_is_reach) begin
                            w_state_nxt = ST_LOCK;
                        end else begin
                            w_addr_e_nxt = r_addr_w;
                            w_addr_w_nxt = r_addr_w + ROW_INC;
                            w_we_nxt     = 1'b1;
                            w_state_nxt  = ST_MOVE;
                        end
                    end else if (i_btn_left) begin
                        if (r_col > f_lmin(r_piece, r_rot)) begin
                            w_addr_e_nxt = r_addr_w;
                            w_addr_w_nxt = r_addr_w - 9'd1;
                            w_col_nxt    = r_col - 4'd1;
                            w_we_nxt     = 1'b1;
                            w_state_nxt  = ST_MOVE;
                        end
                    end else if (i_btn_right) begin
                        if (r_col < f_rmax(r_piece, r_rot)) begin
                            w_addr_e_nxt = r_addr_w;
                            w_addr_w_nxt = r_addr_w + 9'd1;
                            w_col_nxt    = r_col + 4'd1;
                            w_we_nxt     = 1'b1;
                            w_state_nxt  = ST_MOVE;
                        end
`ifdef ROTATE_EN
                    end else if (i_btn_rot) begin
                        if ((r_piece == PC_I || r_piece == PC_L1) &&
                            (r_col >= f_lmin(r_piece, w_rot_inc)) &&
                            (r_col <= f_rmax(r_piece, w_rot_inc))) begin
                            w_addr_e_nxt = r_addr_w;
                            w_rot_nxt    = w_rot_inc;
                            w_we_nxt     = 1'b1;
                            w_state_nxt  = ST_MOVE;
                        end
`endif
                    end
                end
                ST_MOVE: begin
                    w_state_nxt = ST_FALL;
                end
                ST_LOCK: begin
                    // Wait one gravity period so the memory settles column heights
                    w_drop_nxt = 1'b0;
                    w_dcnt_nxt = '0;
                    if (i_tick) begin
                        w_state_nxt = ST_SPAWN;
                    end
                end
                ST_CLR: begin
                    w_state_nxt = ST_SPAWN;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs and piece context
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr_w    <= SPAWN_A;
            r_addr_e    <= SPAWN_A;
            r_din       <= 12'h88f;
            r_rot       <= 2'd0;
            r_cnt       <= '0;
            r_game_over <= 1'b0;
            r_piece     <= PC_I;
            r_col       <= SPAWN_COL;
            r_drop      <= 1'b0;
            r_dcnt      <= '0;
        end else begin
            r_we        <= w_we_nxt;
            r_addr_w    <= w_addr_w_nxt;
            r_addr_e    <= w_addr_e_nxt;
            r_din       <= w_din_nxt;
            r_rot       <= w_rot_nxt;
            r_cnt       <= w_cnt_nxt;
            r_game_over <= w_game_over_nxt;
            r_piece     <= w_piece_nxt;
            r_col       <= w_col_nxt;
            r_drop      <= w_drop_nxt;
            r_dcnt      <= w_dcnt_nxt;
        end
    end

    assign o_we          = r_we;
    assign o_addr_w      = r_addr_w;
    assign o_addr_e      = r_addr_e;
    assign o_din         = r_din;
    assign o_din_e       = r_din;
    assign o_left_rotate = r_rot;
    assign o_piece_cnt   = r_cnt;
    assign o_game_over   = r_game_over;
    assign o_state       = r_state;

endmodule
